multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the MIPS datapath.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB states, and drives the datapath control strobes state by state.
- Decodes the same opcode set and control polarities as the single-cycle decoder: ADD=6'b000001, LW=6'b000010, SW=6'b000100.
- Shares one memory port between instruction fetch and data access using a mem_ready handshake, with a wait timeout.

Parameters:
- TIMEOUT, 16: maximum cycles to wait for mem_ready on one access before entering ERR; minimum 2.
- CNT_W, 8: width of illegal_cnt.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  permits a new fetch to start.
- opcode  input  6  opcode field from the instruction register; valid from the DECODE cycle onward.
- mem_ready  input  1  memory completes the current access this cycle.
- PC_Write  output  1  PC update strobe.
- IR_Write  output  1  instruction register load strobe.
- I_or_D  output  1  memory address select: 0 = PC, 1 = ALU result.
- Reg_Dst  output  1  1 = rd, 0 = rt.
- Reg_Write  output  1  register file write enable.
- Alu_Src  output  1  1 = immediate, 0 = register.
- Alu_Control  output  3  ALU operation select.
- Mem_Read  output  1  memory read request.
- Mem_Write  output  1  memory write request.
- Mem_To_Reg  output  1  1 = ALU result, 0 = memory data.
- instr_done  output  1  one-cycle pulse when an instruction retires.
- err  output  1  sticky memory timeout flag.
- illegal_cnt  output  CNT_W  saturating count of undefined opcodes.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=FETCH, req_active=0, wait_cnt=0, op_q=0, illegal_cnt=0, err=0.
  - Every output is 0 during reset and in the first cycle after release.
- Strobe timing:
  - PC_Write, IR_Write and instr_done are Mealy strobes, as defined below.
  - All other outputs are decoded from state and op_q only; they have no combinational path from opcode.
- FETCH:
  - If run=1 or req_active=1: Mem_Read=1, I_or_D=0, req_active<=1.
  - Once a request is active it is held until mem_ready, regardless of run.
  - If run=0 and req_active=0: Mem_Read=0, stay in FETCH, wait_cnt holds at 0.
  - When mem_ready=1 with Mem_Read=1: IR_Write=1 and PC_Write=1 that cycle; req_active<=0; next state DECODE.
- DECODE:
  - op_q<=opcode.
  - ADD, LW or SW: next state EXEC.
  - Any other opcode: illegal_cnt increments, saturating at all-ones; next state FETCH; no instr_done.
  - All strobes are 0 in DECODE.
- EXEC:
  - Alu_Control=3'b101.
  - Alu_Src=0 for ADD, 1 for LW/SW.
  - Next state: ADD goes to WB; LW/SW go to MEM.
- MEM:
  - I_or_D=1, Alu_Src=1, Alu_Control=3'b101.
  - Mem_Read=1 for LW; Mem_Write=1 for SW.
  - Waits for mem_ready.
  - On mem_ready: SW goes to FETCH with instr_done=1; LW goes to WB.
- WB:
  - Reg_Write=1, instr_done=1, one cycle; next state FETCH.
  - ADD: Reg_Dst=1, Mem_To_Reg=1, Alu_Control=3'b101.
  - LW: Reg_Dst=0, Mem_To_Reg=0.
- Timeout:
  - wait_cnt increments each cycle a request is outstanding without mem_ready, in FETCH or MEM.
  - wait_cnt clears on mem_ready and on state entry.
  - If wait_cnt==TIMEOUT-1 and mem_ready=0: next state ERR.
  - mem_ready arriving on that same cycle wins; no error.
- ERR:
  - err=1; all other outputs 0.
  - Terminal state; exits only via reset.
- Mid-operation events:
  - Reset mid-instruction aborts immediately; no partial strobes remain.
  - run deasserting mid-instruction does not stop it; it only blocks the next fetch.
- Latency with zero-wait memory (mem_ready=1 on the first request cycle):
  - ADD: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LW: 5 cycles.
  - SW: 4 cycles.

Test Plan:
- Reset release, run=1, opcode=ADD, mem_ready tied 1 -> states cycle F,D,E,W. IR_Write and PC_Write high in F. Reg_Write=1, Reg_Dst=1, Mem_To_Reg=1 in W. instr_done every 4th cycle.
- LW with mem_ready delayed 3 cycles in MEM -> Mem_Read=1 and I_or_D=1 held for 4 cycles, then WB with Reg_Dst=0, Mem_To_Reg=0. Total 8 cycles.
- SW, mem_ready=1 -> Mem_Write=1 for exactly one cycle, Reg_Write never asserted, instr_done in the MEM cycle, next cycle FETCH.
- opcode=6'b111111, repeated 300 times with CNT_W=8 -> no instr_done, no Reg_Write or Mem_Write; illegal_cnt saturates at 255.
- mem_ready held 0 in FETCH, TIMEOUT=16 -> ERR after 16 request cycles; err=1 and all other outputs 0 until rst_n pulse. Repeat with mem_ready on cycle 16 -> DECODE, no err.
- run dropped to 0 after the FETCH request issues -> Mem_Read stays high until mem_ready; the instruction completes; the following FETCH idles with Mem_Read=0. Assert rst_n=0 mid-MEM -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Handshake and control-strobe bundle between the multi-cycle sequencer and
// the MIPS datapath / shared memory port.
interface multicycle_controller_if #(
  parameter int CNT_W = 8
);
  logic             run;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             PC_Write;
  logic             IR_Write;
  logic             I_or_D;
  logic             Reg_Dst;
  logic             Reg_Write;
  logic             Alu_Src;
  logic [2:0]       Alu_Control;
  logic             Mem_Read;
  logic             Mem_Write;
  logic             Mem_To_Reg;
  logic             instr_done;
  logic             err;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    input  run, opcode, mem_ready,
    output PC_Write, IR_Write, I_or_D, Reg_Dst, Reg_Write, Alu_Src,
           Alu_Control, Mem_Read, Mem_Write, Mem_To_Reg, instr_done,
           err, illegal_cnt
  );

  modport slave (
    output run, opcode, mem_ready,
    input  PC_Write, IR_Write, I_or_D, Reg_Dst, Reg_Write, Alu_Src,
           Alu_Control, Mem_Read, Mem_Write, Mem_To_Reg, instr_done,
           err, illegal_cnt
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory
// port with a mem_ready handshake, a per-access wait timeout and a sticky ERR.
module multicycle_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_LW  = 6'b000010;
  localparam logic [5:0] OP_SW  = 6'b000100;
  localparam logic [2:0] ALU_ADD = 3'b101;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_ERR
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_req_active;
  logic             w_req_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_next;
  logic [5:0]       r_op_q;
  logic [5:0]       w_op_next;
  logic [CNT_W-1:0] r_illegal_cnt;
  logic [CNT_W-1:0] w_illegal_next;
  // Holds everything quiet for the first cycle after reset release.
  logic             r_armed;

  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_i_or_d;
  logic       w_reg_dst;
  logic       w_reg_write;
  logic       w_alu_src;
  logic [2:0] w_alu_control;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_mem_to_reg;
  logic       w_instr_done;
  logic       w_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_FETCH;
      r_req_active  <= 1'b0;
      r_wait_cnt    <= '0;
      r_op_q        <= '0;
      r_illegal_cnt <= '0;
      r_armed       <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_req_active  <= w_req_next;
      r_wait_cnt    <= w_wait_next;
      r_op_q        <= w_op_next;
      r_illegal_cnt <= w_illegal_next;
      r_armed       <= 1'b1;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_req_next     = r_req_active;
    w_wait_next    = r_wait_cnt;
    w_op_next      = r_op_q;
    w_illegal_next = r_illegal_cnt;
    w_pc_write     = 1'b0;
    w_ir_write     = 1'b0;
    w_i_or_d       = 1'b0;
    w_reg_dst      = 1'b0;
    w_reg_write    = 1'b0;
    w_alu_src      = 1'b0;
    w_alu_control  = 3'b000;
    w_mem_read     = 1'b0;
    w_mem_write    = 1'b0;
    w_mem_to_reg   = 1'b0;
    w_instr_done   = 1'b0;
    w_err          = 1'b0;

    case (r_state)
      S_FETCH: begin
        // An issued fetch stays on the bus until served, even if run drops.
        if (r_armed && (bus.run || r_req_active)) begin
          w_mem_read = 1'b1;
          if (bus.mem_ready) begin
            w_ir_write   = 1'b1;
            w_pc_write   = 1'b1;
            w_req_next   = 1'b0;
            w_wait_next  = '0;
            w_state_next = S_DECODE;
          end else begin
            w_req_next = 1'b1;
            if (r_wait_cnt == WAIT_LAST) begin
              w_state_next = S_ERR;
            end else begin
              w_wait_next = r_wait_cnt + 1'b1;
            end
          end
        end
      end

      S_DECODE: begin
        w_op_next   = bus.opcode;
        w_wait_next = '0;
        if (bus.opcode == OP_ADD || bus.opcode == OP_LW || bus.opcode == OP_SW) begin
          w_state_next = S_EXEC;
        end else begin
          if (r_illegal_cnt != {CNT_W{1'b1}}) begin
            w_illegal_next = r_illegal_cnt + 1'b1;
          end
          w_state_next = S_FETCH;
        end
      end

      S_EXEC: begin
        w_alu_control = ALU_ADD;
        w_alu_src     = (r_op_q != OP_ADD);
        w_wait_next   = '0;
        w_state_next  = (r_op_q == OP_ADD) ? S_WB : S_MEM;
      end

      S_MEM: begin
        w_i_or_d      = 1'b1;
        w_alu_src     = 1'b1;
        w_alu_control = ALU_ADD;
        w_mem_read    = (r_op_q == OP_LW);
        w_mem_write   = (r_op_q == OP_SW);
        if (bus.mem_ready) begin
          w_wait_next = '0;
          if (r_op_q == OP_SW) begin
            w_instr_done = 1'b1;
            w_state_next = S_FETCH;
          end else begin
            w_state_next = S_WB;
          end
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_next = S_ERR;
        end else begin
          w_wait_next = r_wait_cnt + 1'b1;
        end
      end

      S_WB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_wait_next  = '0;
        if (r_op_q == OP_ADD) begin
          w_reg_dst     = 1'b1;
          w_mem_to_reg  = 1'b1;
          w_alu_control = ALU_ADD;
        end
        w_state_next = S_FETCH;
      end

      S_ERR: begin
        w_err = 1'b1;
      end

      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  assign bus.PC_Write    = w_pc_write;
  assign bus.IR_Write    = w_ir_write;
  assign bus.I_or_D      = w_i_or_d;
  assign bus.Reg_Dst     = w_reg_dst;
  assign bus.Reg_Write   = w_reg_write;
  assign bus.Alu_Src     = w_alu_src;
  assign bus.Alu_Control = w_alu_control;
  assign bus.Mem_Read    = w_mem_read;
  assign bus.Mem_Write   = w_mem_write;
  assign bus.Mem_To_Reg  = w_mem_to_reg;
  assign bus.instr_done  = w_instr_done;
  assign bus.err         = w_err;
  assign bus.illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller with hand sequences
// for timeout, illegal-opcode saturation and asynchronous reset.
module tb_multicycle_controller;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;
  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_LW  = 6'b000010;
  localparam logic [5:0] OP_SW  = 6'b000100;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  multicycle_controller_if #(.CNT_W(CNT_W)) bus ();

  multicycle_controller #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PC_Write, IR_Write, I_or_D, Reg_Dst, Reg_Write, Alu_Src, Alu_Control,
  //  Mem_Read, Mem_Write, Mem_To_Reg, instr_done, err}
  logic [13:0] act_out;
  assign act_out = {bus.PC_Write, bus.IR_Write, bus.I_or_D, bus.Reg_Dst,
                    bus.Reg_Write, bus.Alu_Src, bus.Alu_Control, bus.Mem_Read,
                    bus.Mem_Write, bus.Mem_To_Reg, bus.instr_done, bus.err};

  function automatic logic [13:0] mk(input logic pcw, input logic irw,
                                     input logic iod, input logic rdst,
                                     input logic rw, input logic asrc,
                                     input logic [2:0] alu, input logic mr,
                                     input logic mw, input logic m2r,
                                     input logic done, input logic e);
    return {pcw, irw, iod, rdst, rw, asrc, alu, mr, mw, m2r, done, e};
  endfunction

  logic [13:0] O_ZERO, O_FHIT, O_FREQ, O_EXADD, O_EXLS, O_WBADD, O_WBLW,
               O_MEMLW, O_MEMSWD, O_ERR;

  typedef struct packed {
    logic        run;
    logic [5:0]  op;
    logic        rdy;
    logic [13:0] exp;
  } vec_t;

  localparam int NVEC = 31;
  vec_t tbl [NVEC];

  function automatic vec_t mkv(input logic run, input logic [5:0] op,
                               input logic rdy, input logic [13:0] exp);
    vec_t v;
    v.run = run;
    v.op  = op;
    v.rdy = rdy;
    v.exp = exp;
    return v;
  endfunction

  task automatic chk_val(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [13:0] exp);
    n_checks++;
    if (act_out !== exp) begin
      n_errors++;
      $display("FAIL %s: outputs got %b expected %b", name, act_out, exp);
    end
  endtask

  // One clock cycle: drive at negedge, compare 1 ns later, end on posedge.
  task automatic apply(input string name, input logic run, input logic [5:0] op,
                       input logic rdy, input logic [13:0] exp);
    @(negedge clk);
    bus.run       = run;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    #1;
    chk_out(name, exp);
    $display("%s run=%0b op=%b rdy=%0b out=%b cnt=%0d", name, run, op, rdy,
             act_out, bus.illegal_cnt);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.run       = 1'b1;
    bus.opcode    = OP_ADD;
    bus.mem_ready = 1'b1;
    #1;
    chk_out("in_reset", O_ZERO);
    chk_val("in_reset_cnt", int'(bus.illegal_cnt), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_out("after_release", O_ZERO);
    $display("reset released out=%b cnt=%0d", act_out, bus.illegal_cnt);
    @(posedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt;
    n_checks = 0;
    n_errors = 0;
    rst_n         = 1'b0;
    bus.run       = 1'b0;
    bus.opcode    = '0;
    bus.mem_ready = 1'b0;

    O_ZERO   = '0;
    O_FHIT   = mk(1, 1, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0);
    O_FREQ   = mk(0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0);
    O_EXADD  = mk(0, 0, 0, 0, 0, 0, 3'b101, 0, 0, 0, 0, 0);
    O_EXLS   = mk(0, 0, 0, 0, 0, 1, 3'b101, 0, 0, 0, 0, 0);
    O_WBADD  = mk(0, 0, 0, 1, 1, 0, 3'b101, 0, 0, 1, 1, 0);
    O_WBLW   = mk(0, 0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 1, 0);
    O_MEMLW  = mk(0, 0, 1, 0, 0, 1, 3'b101, 1, 0, 0, 0, 0);
    O_MEMSWD = mk(0, 0, 1, 0, 0, 1, 3'b101, 0, 1, 0, 1, 0);
    O_ERR    = mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1);

    // Two ADDs back to back with zero-wait memory.
    tbl[0]  = mkv(1, OP_ADD, 1, O_FHIT);
    tbl[1]  = mkv(1, OP_ADD, 1, O_ZERO);
    tbl[2]  = mkv(1, OP_ADD, 1, O_EXADD);
    tbl[3]  = mkv(1, OP_ADD, 1, O_WBADD);
    tbl[4]  = mkv(1, OP_ADD, 1, O_FHIT);
    tbl[5]  = mkv(1, OP_ADD, 1, O_ZERO);
    tbl[6]  = mkv(1, OP_ADD, 1, O_EXADD);
    tbl[7]  = mkv(1, OP_ADD, 1, O_WBADD);
    // LW with three wait cycles in MEM: 8 cycles total.
    tbl[8]  = mkv(1, OP_LW, 1, O_FHIT);
    tbl[9]  = mkv(1, OP_LW, 0, O_ZERO);
    tbl[10] = mkv(1, OP_LW, 0, O_EXLS);
    tbl[11] = mkv(1, OP_LW, 0, O_MEMLW);
    tbl[12] = mkv(1, OP_LW, 0, O_MEMLW);
    tbl[13] = mkv(1, OP_LW, 0, O_MEMLW);
    tbl[14] = mkv(1, OP_LW, 1, O_MEMLW);
    tbl[15] = mkv(1, OP_LW, 1, O_WBLW);
    // SW retires in its MEM cycle.
    tbl[16] = mkv(1, OP_SW, 1, O_FHIT);
    tbl[17] = mkv(1, OP_SW, 1, O_ZERO);
    tbl[18] = mkv(1, OP_SW, 1, O_EXLS);
    tbl[19] = mkv(1, OP_SW, 1, O_MEMSWD);
    // One illegal opcode, then idle.
    tbl[20] = mkv(1, OP_BAD, 1, O_FHIT);
    tbl[21] = mkv(1, OP_BAD, 1, O_ZERO);
    tbl[22] = mkv(0, OP_ADD, 1, O_ZERO);
    // run drops after the fetch request issues.
    tbl[23] = mkv(1, OP_ADD, 0, O_FREQ);
    tbl[24] = mkv(0, OP_ADD, 0, O_FREQ);
    tbl[25] = mkv(0, OP_ADD, 1, O_FHIT);
    tbl[26] = mkv(0, OP_ADD, 1, O_ZERO);
    tbl[27] = mkv(0, OP_ADD, 1, O_EXADD);
    tbl[28] = mkv(0, OP_ADD, 1, O_WBADD);
    tbl[29] = mkv(0, OP_ADD, 1, O_ZERO);
    tbl[30] = mkv(0, OP_ADD, 0, O_ZERO);

    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      apply($sformatf("vec%0d", i), tbl[i].run, tbl[i].op, tbl[i].rdy, tbl[i].exp);
    end
    #2;
    chk_val("table_illegal_cnt", int'(bus.illegal_cnt), 1);

    // Illegal opcode saturation at 255 over 300 instructions.
    do_reset();
    exp_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      apply($sformatf("ill%0d_F", i), 1, OP_BAD, 1, O_FHIT);
      apply($sformatf("ill%0d_D", i), 1, OP_BAD, 1, O_ZERO);
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      #2;
      chk_val($sformatf("ill%0d_cnt", i), int'(bus.illegal_cnt), exp_cnt);
    end

    // Fetch timeout: 16 unanswered request cycles, then sticky ERR.
    do_reset();
    for (int i = 0; i < TIMEOUT; i++) begin
      apply($sformatf("fto%0d", i), 1, OP_ADD, 0, O_FREQ);
    end
    for (int i = 0; i < 4; i++) begin
      apply($sformatf("err%0d", i), 1, OP_ADD, (i % 2 == 0), O_ERR);
    end

    // mem_ready on the 16th request cycle wins over the timeout.
    do_reset();
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      apply($sformatf("fwin%0d", i), 1, OP_ADD, 0, O_FREQ);
    end
    apply("fwin_hit", 1, OP_ADD, 1, O_FHIT);
    apply("fwin_dec", 1, OP_ADD, 1, O_ZERO);
    apply("fwin_exe", 1, OP_ADD, 1, O_EXADD);
    apply("fwin_wb", 1, OP_ADD, 1, O_WBADD);

    // Data-access timeout in MEM.
    do_reset();
    apply("mto_F", 1, OP_LW, 1, O_FHIT);
    apply("mto_D", 1, OP_LW, 0, O_ZERO);
    apply("mto_E", 1, OP_LW, 0, O_EXLS);
    for (int i = 0; i < TIMEOUT; i++) begin
      apply($sformatf("mto%0d", i), 0, OP_LW, 0, O_MEMLW);
    end
    apply("mto_err", 1, OP_LW, 1, O_ERR);

    // Asynchronous reset in the middle of a LW data access.
    do_reset();
    apply("ar_illF", 1, OP_BAD, 1, O_FHIT);
    apply("ar_illD", 1, OP_BAD, 1, O_ZERO);
    apply("ar_F", 1, OP_LW, 1, O_FHIT);
    apply("ar_D", 1, OP_LW, 0, O_ZERO);
    apply("ar_E", 1, OP_LW, 0, O_EXLS);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk_out("ar_mem", O_MEMLW);
    chk_val("ar_cnt_before", int'(bus.illegal_cnt), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("ar_async", O_ZERO);
    chk_val("ar_async_cnt", int'(bus.illegal_cnt), 0);
    $display("async reset mid-MEM out=%b cnt=%0d", act_out, bus.illegal_cnt);
    do_reset();
    apply("ar_post_F", 1, OP_ADD, 1, O_FHIT);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
